// File: rtl/rca_pr_scheduler.sv
// Partial-reconfiguration scheduler: drains a target RCA slot, starts reconfiguration and tracks per-slot config.
// Optional RCA_PR_TIMEOUT_EN adds drain and reconfiguration timeouts (status TIMEOUT).
module rca_pr_scheduler #(
    parameter int NUM_SLOTS     = 4,
    parameter int CFG_ID_W      = 5,
    parameter int DRAIN_TIMEOUT = 255,
    parameter int PR_TIMEOUT    = 65535,
    localparam int SLOT_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [SLOT_W-1:0]             req_slot,
    input  logic [CFG_ID_W-1:0]           req_cfg_id,
    input  logic [NUM_SLOTS-1:0]          slot_busy,
    output logic [NUM_SLOTS-1:0]          slot_lock,
    output logic                          pr_start,
    output logic [SLOT_W-1:0]             pr_slot,
    output logic [CFG_ID_W-1:0]           pr_cfg_id,
    input  logic                          pr_done,
    input  logic                          pr_error,
    output logic                          cmpl_valid,
    output logic [1:0]                    cmpl_status,
    output logic [SLOT_W-1:0]             cmpl_slot,
    output logic [NUM_SLOTS-1:0]          slot_cfg_valid,
    output logic [NUM_SLOTS*CFG_ID_W-1:0] slot_cfg_id,
    output logic                          pr_request_pending
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRAIN   = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_SKIPPED = 2'b01;
    localparam logic [1:0] ST_PR_ERR  = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    logic [2:0]              state_r, state_s;
    logic [1:0]              status_s;
    logic                    req_ready_r, pr_start_r, cmpl_valid_r;
    logic [1:0]              cmpl_status_r;
    logic [SLOT_W-1:0]       slot_r, cmpl_slot_r;
    logic [CFG_ID_W-1:0]     cfg_r;
    logic [NUM_SLOTS-1:0]    slot_lock_r, cfg_valid_r;
    logic [CFG_ID_W-1:0]     cfg_id_r [NUM_SLOTS];
    logic                    accept_s, hit_s, skip_s, enter_release_s;

`ifdef RCA_PR_TIMEOUT_EN
    localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int PR_W    = $clog2(PR_TIMEOUT + 1);
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic [PR_W-1:0]    wait_cnt_r;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = DRAIN_TIMEOUT[0] ^ PR_TIMEOUT[0];
`endif

    assign accept_s        = req_valid & req_ready_r;
    assign hit_s           = cfg_valid_r[req_slot] & (cfg_id_r[req_slot] == req_cfg_id);
    assign skip_s          = accept_s & hit_s;
    assign enter_release_s = (state_s == S_RELEASE) & (state_r != S_RELEASE);

    // Next-state and completion-status decode
    always_comb begin
        state_s  = state_r;
        status_s = ST_OK;
        case (state_r)
            S_IDLE: begin
                if (accept_s && !hit_s) state_s = S_DRAIN;
                else                    state_s = S_IDLE;
            end
            S_DRAIN: begin
                if (!slot_busy[slot_r]) begin
                    state_s = S_START;
                end else begin
`ifdef RCA_PR_TIMEOUT_EN
                    if (drain_cnt_r == DRAIN_W'(DRAIN_TIMEOUT - 1)) begin
                        state_s  = S_RELEASE;
                        status_s = ST_TIMEOUT;
                    end else begin
                        state_s = S_DRAIN;
                    end
`else
                    state_s = S_DRAIN;
`endif
                end
            end
            S_START: state_s = S_WAIT;
            S_WAIT: begin
                if (pr_error) begin
                    state_s  = S_RELEASE;
                    status_s = ST_PR_ERR;
                end else if (pr_done) begin
                    state_s  = S_RELEASE;
                    status_s = ST_OK;
                end else begin
`ifdef RCA_PR_TIMEOUT_EN
                    if (wait_cnt_r == PR_W'(PR_TIMEOUT - 1)) begin
                        state_s  = S_RELEASE;
                        status_s = ST_TIMEOUT;
                    end else begin
                        state_s = S_WAIT;
                    end
`else
                    state_s = S_WAIT;
`endif
                end
            end
            S_RELEASE: state_s = S_IDLE;
            default:   state_s = S_IDLE;
        endcase
    end

    // Control state, request latch, lock, completion and per-slot config registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= S_IDLE;
            req_ready_r   <= 1'b0;
            pr_start_r    <= 1'b0;
            cmpl_valid_r  <= 1'b0;
            cmpl_status_r <= ST_OK;
            cmpl_slot_r   <= '0;
            slot_r        <= '0;
            cfg_r         <= '0;
            slot_lock_r   <= '0;
            cfg_valid_r   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) cfg_id_r[i] <= '0;
        end else begin
            state_r      <= state_s;
            req_ready_r  <= (state_s == S_IDLE);
            pr_start_r   <= (state_s == S_START);
            cmpl_valid_r <= skip_s | enter_release_s;
            if (accept_s) begin
                slot_r <= req_slot;
                cfg_r  <= req_cfg_id;
            end
            if (accept_s && !hit_s) slot_lock_r <= NUM_SLOTS'(1) << req_slot;
            else if (state_r == S_RELEASE) slot_lock_r <= '0;
            if (skip_s) begin
                cmpl_status_r <= ST_SKIPPED;
                cmpl_slot_r   <= req_slot;
            end else if (enter_release_s) begin
                cmpl_status_r <= status_s;
                cmpl_slot_r   <= slot_r;
                if (status_s == ST_OK) begin
                    cfg_valid_r[slot_r] <= 1'b1;
                    cfg_id_r[slot_r]    <= cfg_r;
                end else begin
                    cfg_valid_r[slot_r] <= 1'b0;
                end
            end
        end
    end

`ifdef RCA_PR_TIMEOUT_EN
    // Busy-cycle counter in DRAIN and elapsed-cycle counter in WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt_r <= '0;
            wait_cnt_r  <= '0;
        end else begin
            drain_cnt_r <= (state_r == S_DRAIN && slot_busy[slot_r]) ? drain_cnt_r + DRAIN_W'(1) : '0;
            wait_cnt_r  <= (state_r == S_WAIT) ? wait_cnt_r + PR_W'(1) : '0;
        end
    end
`endif

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_cfg_flat
        assign slot_cfg_id[g*CFG_ID_W +: CFG_ID_W] = cfg_id_r[g];
    end

    assign req_ready          = req_ready_r;
    assign slot_lock          = slot_lock_r;
    assign pr_start           = pr_start_r;
    assign pr_slot            = slot_r;
    assign pr_cfg_id          = cfg_r;
    assign cmpl_valid         = cmpl_valid_r;
    assign cmpl_status        = cmpl_status_r;
    assign cmpl_slot          = cmpl_slot_r;
    assign slot_cfg_valid     = cfg_valid_r;
    assign pr_request_pending = rst & ((state_r != S_IDLE) | req_valid);

endmodule

// File: tb/tb_rca_pr_scheduler.sv
// Directed self-checking bench for rca_pr_scheduler; outputs sampled on the falling clock edge.
module tb_rca_pr_scheduler;

`ifdef RCA_PR_TIMEOUT_EN
    localparam int BUSY_CYC = 6;
`else
    localparam int BUSY_CYC = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_slot;
    logic [4:0]  req_cfg_id;
    logic [3:0]  slot_busy, slot_lock;
    logic        pr_start;
    logic [1:0]  pr_slot;
    logic [4:0]  pr_cfg_id;
    logic        pr_done, pr_error;
    logic        cmpl_valid;
    logic [1:0]  cmpl_status;
    logic [1:0]  cmpl_slot;
    logic [3:0]  slot_cfg_valid;
    logic [19:0] slot_cfg_id;
    logic        pr_request_pending;

    int checks   = 0;
    int failures = 0;

    rca_pr_scheduler #(.NUM_SLOTS(4), .CFG_ID_W(5), .DRAIN_TIMEOUT(8), .PR_TIMEOUT(65535)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_slot(req_slot), .req_cfg_id(req_cfg_id), .slot_busy(slot_busy),
        .slot_lock(slot_lock), .pr_start(pr_start), .pr_slot(pr_slot),
        .pr_cfg_id(pr_cfg_id), .pr_done(pr_done), .pr_error(pr_error),
        .cmpl_valid(cmpl_valid), .cmpl_status(cmpl_status), .cmpl_slot(cmpl_slot),
        .slot_cfg_valid(slot_cfg_valid), .slot_cfg_id(slot_cfg_id),
        .pr_request_pending(pr_request_pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] slot, input logic [4:0] cfg);
        req_valid  = 1'b1;
        req_slot   = slot;
        req_cfg_id = cfg;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_slot = 2'd0; req_cfg_id = 5'd0;
        slot_busy = 4'b0000; pr_done = 1'b0; pr_error = 1'b0;
        repeat (2) step();
        req_valid = 1'b1; #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_lock", 32'(slot_lock), 32'd0);
        check("rst_pr_start", 32'(pr_start), 32'd0);
        check("rst_cmpl_valid", 32'(cmpl_valid), 32'd0);
        check("rst_cmpl_status", 32'(cmpl_status), 32'd0);
        check("rst_cmpl_slot", 32'(cmpl_slot), 32'd0);
        check("rst_pr_slot_cfg", 32'({pr_slot, pr_cfg_id}), 32'd0);
        check("rst_cfg_valid", 32'(slot_cfg_valid), 32'd0);
        check("rst_cfg_id", 32'(slot_cfg_id), 32'd0);
        check("rst_pending", 32'(pr_request_pending), 32'd0);
        req_valid = 1'b0; rst = 1'b1;
        step();
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_pending", 32'(pr_request_pending), 32'd0);

        // slot 1 cfg 3, idle slot, pr_done 5 cycles after pr_start
        send(2'd1, 5'd3); #1;
        check("t1_pending_c0", 32'(pr_request_pending), 32'd1);
        step(); req_valid = 1'b0;
        check("t1_lock_c1", 32'(slot_lock), 32'h2);
        check("t1_no_start_c1", 32'(pr_start), 32'd0);
        check("t1_ready_c1", 32'(req_ready), 32'd0);
        step();
        check("t1_start_c2", 32'(pr_start), 32'd1);
        check("t1_pr_slot_cfg", 32'({pr_slot, pr_cfg_id}), 32'({2'd1, 5'd3}));
        step();
        check("t1_start_pulse_c3", 32'(pr_start), 32'd0);
        repeat (3) step();
        step(); pr_done = 1'b1;
        check("t1_no_cmpl_c7", 32'(cmpl_valid), 32'd0);
        check("t1_lock_c7", 32'(slot_lock), 32'h2);
        step(); pr_done = 1'b0;
        check("t1_cmpl_c8", 32'({cmpl_valid, cmpl_status, cmpl_slot}), 32'({1'b1, 2'b00, 2'd1}));
        check("t1_lock_c8", 32'(slot_lock), 32'h2);
        check("t1_cfg_valid", 32'(slot_cfg_valid), 32'h2);
        check("t1_cfg_id", 32'(slot_cfg_id), 32'h00060);
        step();
        check("t1_unlock_c9", 32'(slot_lock), 32'd0);
        check("t1_cmpl_pulse_c9", 32'(cmpl_valid), 32'd0);
        check("t1_ready_c9", 32'(req_ready), 32'd1);

        // repeat of loaded config is skipped
        send(2'd1, 5'd3);
        step(); req_valid = 1'b0;
        check("skip_cmpl", 32'({cmpl_valid, cmpl_status, cmpl_slot}), 32'({1'b1, 2'b01, 2'd1}));
        check("skip_lock", 32'(slot_lock), 32'd0);
        check("skip_ready", 32'(req_ready), 32'd1);
        step();
        check("skip_no_start", 32'(pr_start), 32'd0);
        check("skip_cmpl_pulse", 32'(cmpl_valid), 32'd0);

        // slot 2 busy; stray pr_done during DRAIN is ignored
        slot_busy = 4'b0100; send(2'd2, 5'd7);
        for (int i = 1; i < BUSY_CYC; i++) begin
            step();
            req_valid = 1'b0;
            pr_done = (i == 3);
            check("busy_lock", 32'(slot_lock), 32'h4);
            check("busy_no_start", 32'(pr_start), 32'd0);
            check("busy_no_cmpl", 32'(cmpl_valid), 32'd0);
        end
        step(); slot_busy = 4'b0000; pr_done = 1'b0;
        check("busy_fall_no_start", 32'(pr_start), 32'd0);
        step();
        check("busy_start", 32'(pr_start), 32'd1);
        check("busy_pr_slot_cfg", 32'({pr_slot, pr_cfg_id}), 32'({2'd2, 5'd7}));
        step(); pr_done = 1'b1;
        step(); pr_done = 1'b0;
        check("busy_cmpl", 32'({cmpl_valid, cmpl_status, cmpl_slot}), 32'({1'b1, 2'b00, 2'd2}));
        check("busy_cfg_valid", 32'(slot_cfg_valid), 32'h6);
        check("busy_cfg_id", 32'(slot_cfg_id), 32'h01C60);
        step();

        // pr_done and pr_error together on slot 1
        send(2'd1, 5'd4);
        step(); req_valid = 1'b0;
        step();
        check("dual_start", 32'(pr_start), 32'd1);
        step(); pr_done = 1'b1; pr_error = 1'b1;
        step(); pr_done = 1'b0; pr_error = 1'b0;
        check("dual_cmpl", 32'({cmpl_valid, cmpl_status, cmpl_slot}), 32'({1'b1, 2'b10, 2'd1}));
        check("dual_cfg_valid", 32'(slot_cfg_valid), 32'h4);
        check("dual_lock_release", 32'(slot_lock), 32'h2);
        step();
        check("dual_unlock", 32'(slot_lock), 32'd0);

        // reset asserted while waiting for reconfiguration
        send(2'd0, 5'd9);
        step(); req_valid = 1'b0;
        step();
        check("rw_start", 32'(pr_start), 32'd1);
        step(); rst = 1'b0; pr_done = 1'b1; #1;
        check("rw_lock", 32'(slot_lock), 32'd0);
        check("rw_ready", 32'(req_ready), 32'd0);
        check("rw_pr_slot_cfg", 32'({pr_slot, pr_cfg_id}), 32'd0);
        check("rw_cfg", 32'({slot_cfg_valid, slot_cfg_id}), 32'd0);
        check("rw_cmpl", 32'({cmpl_valid, cmpl_status, cmpl_slot}), 32'd0);
        check("rw_pending", 32'(pr_request_pending), 32'd0);
        step(); pr_done = 1'b0; rst = 1'b1;
        check("rw_no_cmpl_in_rst", 32'(cmpl_valid), 32'd0);
        step();
        check("rw_no_cmpl_after", 32'(cmpl_valid), 32'd0);
        check("rw_ready_after", 32'(req_ready), 32'd1);
        send(2'd3, 5'd1);
        step(); req_valid = 1'b0;
        check("rw_new_lock", 32'(slot_lock), 32'h8);
        step();
        check("rw_new_start", 32'({pr_start, pr_slot, pr_cfg_id}), 32'({1'b1, 2'd3, 5'd1}));
        step(); pr_done = 1'b1;
        step(); pr_done = 1'b0;
        check("rw_new_cmpl", 32'({cmpl_valid, cmpl_status, cmpl_slot}), 32'({1'b1, 2'b00, 2'd3}));
        check("rw_new_cfg", 32'({slot_cfg_valid, slot_cfg_id}), 32'({4'h8, 20'h08000}));
        step();

`ifdef RCA_PR_TIMEOUT_EN
        // drain timeout with slot 3 held busy
        slot_busy = 4'b1000; send(2'd3, 5'd2);
        for (int i = 1; i <= 8; i++) begin
            step();
            req_valid = 1'b0;
            check("to_lock", 32'(slot_lock), 32'h8);
            check("to_no_start", 32'(pr_start), 32'd0);
            check("to_no_cmpl", 32'(cmpl_valid), 32'd0);
        end
        step();
        check("to_cmpl", 32'({cmpl_valid, cmpl_status, cmpl_slot}), 32'({1'b1, 2'b11, 2'd3}));
        check("to_cfg_valid", 32'(slot_cfg_valid), 32'd0);
        check("to_no_start_end", 32'(pr_start), 32'd0);
        step(); slot_busy = 4'b0000;
        check("to_unlock", 32'(slot_lock), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
